uart_tx_frame_gen: RTL



---
 rtl/uart_tx_frame_gen_if.sv | 31 +++
 rtl/uart_tx_frame_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/uart_tx_frame_gen_if.sv
// Parallel-side request bundle and serial-side status of the UART frame generator.
interface uart_tx_frame_gen_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  busy;

    // Data source side: issues words, observes line and busy
    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  busy
    );

    // Frame generator side
    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output busy
    );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one stop bit.
// One CLK cycle is one bit period; TX_OUT and busy are registered.
module uart_tx_frame_gen #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_tx_frame_gen_if.slave      tx_if
);

    localparam int unsigned          CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                  state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic                    par_en_q,  par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic                    tx_out_q,  tx_out_d;
    logic                    busy_q,    busy_d;

    assign tx_if.TX_OUT = tx_out_q;
    assign tx_if.busy   = busy_q;

    // State register and holding registers; reset returns the line to idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
        end
    end

    // Next state plus the line level of the bit period that the next state represents
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_out_d  = 1'b1;
        busy_d    = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (tx_if.Data_Valid) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    data_d    = tx_if.P_DATA;
                    par_en_d  = tx_if.PAR_EN;
                    par_bit_d = (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
                    tx_out_d  = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_START: begin
                state_d  = S_DATA;
                cnt_d    = '0;
                tx_out_d = data_q[0];
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    if (par_en_q) begin
                        state_d  = S_PARITY;
                        tx_out_d = par_bit_q;
                    end else begin
                        state_d  = S_STOP;
                        tx_out_d = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    tx_out_d = data_q[cnt_d];
                end
            end
            S_PARITY: begin
                state_d  = S_STOP;
                tx_out_d = 1'b1;
            end
            S_STOP: begin
                state_d  = S_IDLE;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

endmodule
